// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/kill bus between the decode stage and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 15,
  parameter int STAT_W   = 16
);
  logic                id_valid;
  logic [3:0]          id_src1;
  logic [3:0]          id_src2;
  logic                id_use_src2;
  logic [3:0]          id_dest;
  logic                id_wb_en;
  logic                wb_en;
  logic [3:0]          wb_dest;
  logic                kill_en;
  logic [3:0]          kill_dest;
  logic                stall;
  logic [NUM_REGS-1:0] busy_vec;
  logic [STAT_W-1:0]   stall_cnt;
  logic                err;

  modport master (
    output id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en,
           wb_en, wb_dest, kill_en, kill_dest,
    input  stall, busy_vec, stall_cnt, err
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en,
           wb_en, wb_dest, kill_en, kill_dest,
    output stall, busy_vec, stall_cnt, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, RAW/structural
// hazard stall with same-cycle writeback/kill bypass, stall statistics and a
// sticky protocol-error flag. Index 15 (PC) and any index >= NUM_REGS are
// untracked.
module reg_scoreboard #(
  parameter int NUM_REGS = 15,
  parameter int CNT_W    = 2,
  parameter int STAT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  bus
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef logic signed [SUM_W-1:0] sum_t;

  localparam sum_t PEND_MAX_S = sum_t'(PEND_MAX);

  function automatic logic [CNT_W-1:0] sat_pend(input sum_t v);
    if (v < 0)          return '0;
    if (v > PEND_MAX_S) return PEND_MAX;
    return v[CNT_W-1:0];
  endfunction

  function automatic logic pend_out_of_range(input sum_t v);
    return (v < 0) || (v > PEND_MAX_S);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [CNT_W-1:0]  r_pend [NUM_REGS];
  logic [STAT_W-1:0] r_stall_cnt;
  logic              r_err;

  logic [CNT_W-1:0]    w_pend_next [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc, w_dwb, w_dk;
  logic [NUM_REGS-1:0] w_eff_busy, w_full, w_range_err, w_busy;
  logic                w_raw1, w_raw2, w_struct, w_stall, w_issue;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [3:0] IDX = 4'(gi);
      sum_t w_after_dec;
      sum_t w_sum;

      assign w_dwb[gi] = bus.wb_en   && (bus.wb_dest   == IDX);
      assign w_dk[gi]  = bus.kill_en && (bus.kill_dest == IDX);
      assign w_inc[gi] = w_issue && bus.id_wb_en && (bus.id_dest == IDX);

      // Pending count seen by the hazard check once this cycle's writeback
      // and kill have retired (the register file writes on the falling edge).
      assign w_after_dec = sum_t'(r_pend[gi]) - sum_t'(w_dwb[gi]) - sum_t'(w_dk[gi]);
      assign w_sum       = w_after_dec + sum_t'(w_inc[gi]);

      assign w_eff_busy[gi]  = (w_after_dec > 0);
      assign w_full[gi]      = (r_pend[gi] == PEND_MAX);
      assign w_range_err[gi] = pend_out_of_range(w_sum);
      assign w_pend_next[gi] = sat_pend(w_sum);
      assign w_busy[gi]      = |r_pend[gi];
    end
  endgenerate

  // Select the hazard state of the presented source and destination indices.
  always_comb begin
    w_raw1   = 1'b0;
    w_raw2   = 1'b0;
    w_struct = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((bus.id_src1 == 4'(i)) && w_eff_busy[i])                    w_raw1   = 1'b1;
      if (bus.id_use_src2 && (bus.id_src2 == 4'(i)) && w_eff_busy[i]) w_raw2   = 1'b1;
      if (bus.id_wb_en && (bus.id_dest == 4'(i)) && w_full[i])        w_struct = 1'b1;
    end
  end

  assign w_stall = bus.id_valid && (w_raw1 || w_raw2 || w_struct);
  assign w_issue = bus.id_valid && !w_stall;

  // Pending-write counters: net of issue, writeback and kill, clamped to range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= w_pend_next[i];
    end
  end

  // Sticky error on any counter under/overflow; saturating stall-cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_err <= r_err | (|w_range_err);
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.stall     = w_stall;
  assign bus.busy_vec  = w_busy;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a counter-array model.
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(15), .STAT_W(16)) bus ();

  reg_scoreboard #(.NUM_REGS(15), .CNT_W(2), .STAT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_pend [16];
  bit          m_err;
  int          m_cnt;
  bit          exp_stall;
  logic [14:0] exp_busy;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int v, input int s1, input int s2, input int u2,
                        input int d, input int we, input int wbe, input int wbd,
                        input int ke, input int kd);
    bus.id_valid    = (v != 0);
    bus.id_src1     = 4'(s1);
    bus.id_src2     = 4'(s2);
    bus.id_use_src2 = (u2 != 0);
    bus.id_dest     = 4'(d);
    bus.id_wb_en    = (we != 0);
    bus.wb_en       = (wbe != 0);
    bus.wb_dest     = 4'(wbd);
    bus.kill_en     = (ke != 0);
    bus.kill_dest   = 4'(kd);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int dec_wb(int r);
    return (bus.wb_en && int'(bus.wb_dest) == r) ? 1 : 0;
  endfunction

  function automatic int dec_kill(int r);
    return (bus.kill_en && int'(bus.kill_dest) == r) ? 1 : 0;
  endfunction

  // A source is hazardous if writes remain outstanding after this cycle's
  // writeback/kill retire.
  function automatic bit src_haz(int r);
    if (r >= 15) return 1'b0;
    return (m_pend[r] - dec_wb(r) - dec_kill(r)) > 0;
  endfunction

  function automatic bit model_stall();
    int d;
    bit structural;
    d = int'(bus.id_dest);
    structural = bus.id_wb_en && d < 15 && m_pend[d] == 3;
    return bus.id_valid &&
           (src_haz(int'(bus.id_src1)) || (bus.id_use_src2 && src_haz(int'(bus.id_src2))) || structural);
  endfunction

  task automatic model_clear();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Inputs are already applied: compute what the DUT must show this cycle.
  task automatic present();
    #1;
    exp_stall = model_stall();
    for (int r = 0; r < 15; r++) exp_busy[r] = (m_pend[r] != 0);
    chk_en = 1'b1;
  endtask

  // Clock edge: advance the model with the inputs held during the cycle.
  task automatic advance();
    @(posedge clk);
    chk_en = 1'b0;
    for (int r = 0; r < 15; r++) begin
      int v;
      int inc;
      inc = (!exp_stall && bus.id_valid && bus.id_wb_en && int'(bus.id_dest) == r) ? 1 : 0;
      v = m_pend[r] + inc - dec_wb(r) - dec_kill(r);
      if (v < 0) begin v = 0; m_err = 1'b1; end
      else if (v > 3) begin v = 3; m_err = 1'b1; end
      m_pend[r] = v;
    end
    if (exp_stall && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic step();
    present();
    advance();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    model_clear();
    set_in(1, 3, 4, 1, 5, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy_vec, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("stall", bus.stall, exp_stall);
      chk("busy_vec", bus.busy_vec, exp_busy);
      chk("stall_cnt", bus.stall_cnt, m_cnt);
      chk("err", bus.err, m_err);
    end
  end

  function automatic int pick();
    int x;
    x = $urandom_range(0, 9);
    if (x <= 5) return x;
    if (x <= 7) return $urandom_range(0, 14);
    return 15;
  endfunction

  initial begin
    idle();
    do_reset();

    // RAW on R3 resolved by same-cycle writeback bypass.
    set_in(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); present();
    chk("raw_c0_stall", bus.stall, 0); advance();
    set_in(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); present();
    chk("raw_c1_stall", bus.stall, 1);
    chk("raw_c1_busy3", bus.busy_vec[3], 1); advance();
    present(); advance();
    set_in(1, 3, 0, 0, 0, 0, 1, 3, 0, 0); present();
    chk("raw_c3_bypass", bus.stall, 0); advance();
    idle(); present();
    chk("raw_c4_busy3", bus.busy_vec[3], 0);
    chk("raw_c4_cnt", bus.stall_cnt, 2); advance();

    // Structural hazard: fourth writer to R5.
    do_reset();
    set_in(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step(); step(); step();
    present(); chk("struct_stall", bus.stall, 1); advance();
    set_in(1, 0, 0, 0, 5, 1, 1, 5, 0, 0); present();
    chk("struct_no_bypass", bus.stall, 1); advance();
    set_in(1, 0, 0, 0, 5, 1, 0, 0, 0, 0); present();
    chk("struct_issue", bus.stall, 0); advance();
    idle(); present();
    chk("struct_busy", bus.busy_vec, 15'h0020); advance();

    // Same-cycle issue and writeback on R7 leave pend at 1.
    do_reset();
    set_in(1, 0, 0, 0, 7, 1, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 7, 1, 1, 7, 0, 0); present();
    chk("incdec_stall", bus.stall, 0); advance();
    idle(); present();
    chk("incdec_busy7", bus.busy_vec[7], 1); advance();
    set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0); step();
    idle(); present();
    chk("incdec_drained", bus.busy_vec, 0);
    chk("incdec_err", bus.err, 0); advance();

    // Unused src2, PC indices, wb+kill on R6 with pend 2.
    do_reset();
    set_in(1, 0, 0, 0, 4, 1, 0, 0, 0, 0); step(); step();
    set_in(1, 0, 0, 0, 6, 1, 0, 0, 0, 0); step(); step();
    set_in(1, 0, 4, 0, 0, 0, 0, 0, 0, 0); present();
    chk("src2_unused", bus.stall, 0); advance();
    set_in(1, 0, 4, 1, 0, 0, 0, 0, 0, 0); present();
    chk("src2_used", bus.stall, 1); advance();
    set_in(1, 15, 15, 1, 15, 1, 1, 15, 1, 15); present();
    chk("pc_nostall", bus.stall, 0); advance();
    set_in(1, 6, 0, 0, 0, 0, 1, 6, 1, 6); present();
    chk("wbkill_bypass", bus.stall, 0); advance();
    idle(); present();
    chk("pc_busy", bus.busy_vec, 15'h0010);
    chk("pc_err", bus.err, 0); advance();

    // Underflow sets sticky err.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
    idle(); present();
    chk("uflow_err", bus.err, 1);
    chk("uflow_busy", bus.busy_vec, 0); advance();
    step(); step(); step();
    present(); chk("uflow_sticky", bus.err, 1); advance();

    // Asynchronous reset mid-cycle.
    do_reset();
    set_in(1, 0, 0, 0, 2, 1, 0, 0, 0, 0); step(); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
    set_in(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step();
    present();
    chk("pre_rst_cnt", bus.stall_cnt, 10);
    chk("pre_rst_busy", bus.busy_vec, 15'h0004);
    chk("pre_rst_err", bus.err, 1);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_busy", bus.busy_vec, 0);
    chk("async_cnt", bus.stall_cnt, 0);
    chk("async_err", bus.err, 0);
    chk("async_stall", bus.stall, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int wbd, kd, wbe, ke;
      if (n % 600 == 599) do_reset();
      wbd = pick();
      kd  = pick();
      wbe = (wbd < 15 && m_pend[wbd] > 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 99) == 0);
      ke  = (kd < 15 && m_pend[kd] > 0) ? int'($urandom_range(0, 3) == 0) : int'($urandom_range(0, 199) == 0);
      set_in(int'($urandom_range(0, 3) != 0), pick(), pick(), int'($urandom_range(0, 1)),
             pick(), int'($urandom_range(0, 3) != 0), wbe, wbd, ke, kd);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 15, SHALL set the count of tracked architectural registers R0..R(NUM_REGS-1); index 15 (PC) SHALL be untracked.
REQ-002 Parameter CNT_W, default 2, SHALL set the width of each per-register pending-write counter, giving a maximum of 3 writes in flight.
REQ-003 Parameter STAT_W, default 16, SHALL set the width of the stall statistics counter.
REQ-004 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 id_valid  input  1  SHALL indicate that a decoded instruction is presented for issue.
REQ-007 id_src1, id_src2  input  4 each  SHALL be the source register indices, the same values driven to the register-file read ports.
REQ-008 id_use_src2  input  1  SHALL indicate that id_src2 is a true operand; when 0, src2 is ignored.
REQ-009 id_dest  input  4  SHALL be the destination register of the issuing instruction.
REQ-010 id_wb_en  input  1  SHALL indicate that the issuing instruction will write id_dest.
REQ-011 wb_en  input  1  SHALL be the writeback-enable signal, the same as the register-file write enable.
REQ-012 wb_dest  input  4  SHALL be the writeback destination, the same as the register-file write address.
REQ-013 kill_en  input  1  SHALL indicate that one in-flight writer is cancelled (flush).
REQ-014 kill_dest  input  4  SHALL be the destination of the cancelled writer.
REQ-015 stall  output  1  SHALL, when high, hold the ID stage; it is combinational.
REQ-016 busy_vec  output  15  SHALL have bit i high whenever pend[i] != 0.
REQ-017 stall_cnt  output  STAT_W  SHALL count stall cycles.
REQ-018 err  output  1  SHALL be a sticky protocol-error flag.

Function
REQ-019 Each tracked register i SHALL have counter pend[i], in the range 0..3.
REQ-020 Per cycle, pend[i]_next SHALL equal pend[i] + inc - dec_wb - dec_kill, with each term 0 or 1.
- inc = issue && id_wb_en && id_dest==i
- dec_wb = wb_en && wb_dest==i
- dec_kill = kill_en && kill_dest==i
REQ-021 issue SHALL equal id_valid && !stall.
REQ-022 The RAW hazard condition SHALL be: src1 is hazardous if pend[id_src1] != 0; src2 is hazardous if id_use_src2 && pend[id_src2] != 0.
REQ-023 Writeback bypass: a writeback to register r in the same cycle SHALL remove r's contribution to the hazard check when pend[r]==1, because the register file writes on the falling edge and the read then sees the new value.
REQ-024 A kill in the same cycle SHALL likewise remove the hazard when the combined decrements bring pend to 0.
REQ-025 The structural hazard condition SHALL be: id_wb_en && pend[id_dest]==3, with no bypass applied.
REQ-026 stall SHALL equal id_valid && (RAW hazard || structural hazard).
REQ-027 Any source or destination index equal to 15 SHALL never cause a stall and SHALL never modify a counter.
REQ-028 Simultaneous inc and dec on the same register SHALL leave pend unchanged.
REQ-029 Simultaneous wb and kill on the same register SHALL decrement pend by 2.
REQ-030 A decrement that would take pend below 0 SHALL clamp pend at 0 and set err.
REQ-031 An increment that would exceed 3 cannot occur because of REQ-025; if the net result nonetheless exceeds 3, pend SHALL saturate at 3 and err SHALL be set.
REQ-032 err, once set, SHALL remain set until rst.
REQ-033 stall_cnt SHALL increment by 1 on each cycle with stall=1 and SHALL saturate at all-ones.
REQ-034 The block SHALL have no latency beyond the REQ-020 update: pend changes are visible to the hazard check in the cycle after issue.

Reset
REQ-035 While rst is high, all pend SHALL be 0, busy_vec SHALL be 0, stall_cnt SHALL be 0, and err SHALL be 0, asynchronously.
REQ-036 While rst is high, stall SHALL evaluate to 0 because all pend are 0.
REQ-037 A reset asserted mid-operation SHALL discard all in-flight tracking.
REQ-038 The first rising edge after rst deasserts SHALL process inputs normally.

Verification
REQ-039 Issue ADD R3 (wb) in cycle 0, then in cycle 1 present src1=3 -> stall=1 in cycle 1 and busy_vec[3]=1; wb_en with wb_dest=3 in cycle 3 -> stall=0 in cycle 3 (bypass), busy_vec[3]=0 in cycle 4, stall_cnt=2.
REQ-040 Issue three writers to R5 back-to-back, then a fourth with id_dest=5 -> stall=1 and pend[5] holds at 3; one writeback to R5 -> the fourth issues on the next cycle.
REQ-041 In the same cycle, issue with id_dest=7 and wb_dest=7 while pend[7]=1 -> pend[7] stays 1, busy_vec[7]=1.
REQ-042 Present src2=4 with id_use_src2=0 and pend[4]=2 -> stall=0; present src1=15 or id_dest=15 -> no stall and no counter change.
REQ-043 wb_en with wb_dest=9 while pend[9]=0 -> err=1 and pend[9]=0; err stays 1 until rst.
REQ-044 Assert rst asynchronously mid-cycle with pend[2]=2 and stall_cnt=10 -> busy_vec=0, stall_cnt=0, err=0 immediately, without waiting for a clock edge.
